// File: rtl/seq_stim_ctrl.sv
// Stimulus sequencer and activity monitor for one seq_detector instance.
// Optional toggle counters are enabled with `define SEQ_CTRL_TOGGLE_EN.
module seq_stim_ctrl #(
  parameter int PAT_W = 16,
  parameter int LEN_W = 5,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  output logic             det_x,
  output logic             det_rst,
  input  logic             det_z,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] match_cnt,
  output logic [CNT_W-1:0] x_tgl_cnt,
  output logic [CNT_W-1:0] z_tgl_cnt
);

  typedef enum logic [2:0] {IDLE, CLR, RUN, DRAIN, DONE} state_t;

  state_t           state_q, state_d;
  logic [PAT_W-1:0] sreg_q, sreg_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [LEN_W-1:0] len_c, shamt;
  logic             first_q, first_d;
  logic             det_x_d, det_rst_d, busy_d, done_d;
  logic             clr_cnt, smp;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  assign len_c = (len > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : len;
  assign shamt = LEN_W'(PAT_W) - len_c;

  always_comb begin
    state_d   = state_q;
    sreg_d    = sreg_q;
    rem_d     = rem_q;
    first_d   = first_q;
    det_x_d   = 1'b0;
    det_rst_d = 1'b0;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    clr_cnt   = 1'b0;
    smp       = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        clr_cnt = 1'b1;
        if (len_c == '0) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          state_d   = CLR;
          det_rst_d = 1'b1;
          busy_d    = 1'b1;
          sreg_d    = pattern << shamt;
          rem_d     = len_c;
        end
      end
      CLR: begin
        state_d = RUN;
        busy_d  = 1'b1;
        det_x_d = sreg_q[PAT_W-1];
        sreg_d  = sreg_q << 1;
        first_d = 1'b1;
      end
      RUN: begin
        // detector output lags det_x by one cycle, so the first RUN cycle has nothing to sample
        busy_d  = 1'b1;
        smp     = !first_q;
        first_d = 1'b0;
        rem_d   = rem_q - 1'b1;
        if (rem_q == LEN_W'(1)) begin
          state_d = DRAIN;
        end else begin
          det_x_d = sreg_q[PAT_W-1];
          sreg_d  = sreg_q << 1;
        end
      end
      DRAIN: begin
        smp     = 1'b1;
        state_d = DONE;
        done_d  = 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      sreg_q    <= '0;
      rem_q     <= '0;
      first_q   <= 1'b0;
      det_x     <= 1'b0;
      det_rst   <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      match_cnt <= '0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      rem_q   <= rem_d;
      first_q <= first_d;
      det_x   <= det_x_d;
      det_rst <= det_rst_d;
      busy    <= busy_d;
      done    <= done_d;
      if (clr_cnt)          match_cnt <= '0;
      else if (smp && det_z) match_cnt <= sat_inc(match_cnt);
    end
  end

`ifdef SEQ_CTRL_TOGGLE_EN
  logic prev_x, prev_z;

  always_ff @(posedge clk) begin
    if (!rst) begin
      prev_x    <= 1'b0;
      prev_z    <= 1'b0;
      x_tgl_cnt <= '0;
      z_tgl_cnt <= '0;
    end else if (clr_cnt) begin
      prev_x    <= 1'b0;
      prev_z    <= 1'b0;
      x_tgl_cnt <= '0;
      z_tgl_cnt <= '0;
    end else begin
      if (state_q == RUN) begin
        prev_x <= det_x;
        if (det_x != prev_x) x_tgl_cnt <= sat_inc(x_tgl_cnt);
      end
      if (smp) begin
        prev_z <= det_z;
        if (det_z != prev_z) z_tgl_cnt <= sat_inc(z_tgl_cnt);
      end
    end
  end
`else
  assign x_tgl_cnt = '0;
  assign z_tgl_cnt = '0;
`endif

endmodule

// File: tb/tb_seq_stim_ctrl.sv
// Directed bench for seq_stim_ctrl with a one-cycle loopback detector model.
module tb_seq_stim_ctrl;
`ifdef SEQ_CTRL_TOGGLE_EN
  localparam bit TGL = 1'b1;
`else
  localparam bit TGL = 1'b0;
`endif

  logic        clk = 1'b0, rst = 1'b0;
  logic        start = 1'b0, start2 = 1'b0;
  logic [15:0] pattern = '0, pattern2 = '0;
  logic [4:0]  len = '0, len2 = '0;
  logic        det_x, det_rst, det_z = 1'b0, busy, done;
  logic [7:0]  match_cnt, x_tgl_cnt, z_tgl_cnt;
  logic        det_x2, det_rst2, det_z2 = 1'b0, busy2, done2;
  logic [1:0]  match2, xtgl2, ztgl2;
  int          checks = 0, errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) begin
    det_z  <= det_x;
    det_z2 <= det_x2;
  end

  seq_stim_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .pattern(pattern), .len(len),
    .det_x(det_x), .det_rst(det_rst), .det_z(det_z), .busy(busy), .done(done),
    .match_cnt(match_cnt), .x_tgl_cnt(x_tgl_cnt), .z_tgl_cnt(z_tgl_cnt));

  seq_stim_ctrl #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .start(start2), .pattern(pattern2), .len(len2),
    .det_x(det_x2), .det_rst(det_rst2), .det_z(det_z2), .busy(busy2), .done(done2),
    .match_cnt(match2), .x_tgl_cnt(xtgl2), .z_tgl_cnt(ztgl2));

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Full loopback run; poke re-pulses start with a different pattern mid-run.
  task automatic lb_run(input logic [15:0] pat, input logic [4:0] ln, input int n,
                        input int em, input int et, input bit poke);
    logic [15:0] sh;
    sh = pat << (16 - n);
    pattern = pat; len = ln; start = 1'b1;
    tick();
    start = 1'b0;
    chk("clr_det_rst", det_rst, 1); chk("clr_busy", busy, 1); chk("clr_det_x", det_x, 0);
    for (int i = 0; i < n; i++) begin
      if (poke && i == 2) begin start = 1'b1; pattern = ~pat; len = 5'd3; end
      tick();
      start = 1'b0; pattern = pat; len = ln;
      chk("run_det_x", det_x, sh[15-i]);
      chk("run_busy", busy, 1);
      chk("run_det_rst", det_rst, 0);
    end
    tick();
    chk("drain_det_x", det_x, 0); chk("drain_busy", busy, 1); chk("drain_done", done, 0);
    tick();
    chk("done_pulse", done, 1); chk("done_busy", busy, 0);
    chk("match_cnt", match_cnt, em);
    chk("x_tgl_cnt", x_tgl_cnt, TGL ? et : 0);
    chk("z_tgl_cnt", z_tgl_cnt, TGL ? et : 0);
    tick();
    chk("done_drop", done, 0); chk("match_hold", match_cnt, em);
  endtask

  initial begin
    // reset
    tick(); tick();
    chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_det_x", det_x, 0);
    chk("rst_det_rst", det_rst, 1); chk("rst_match", match_cnt, 0);
    chk("rst_xtgl", x_tgl_cnt, 0); chk("rst_ztgl", z_tgl_cnt, 0);
    rst = 1'b1;
    tick();
    chk("rel_det_rst", det_rst, 0);

    // loopback 0xB6 / 8 bits
    lb_run(16'h00B6, 5'd8, 8, 5, 6, 1'b0);

    // len == 0: immediate done, counters cleared, no detector reset
    pattern = 16'hFFFF; len = 5'd0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("len0_done", done, 1); chk("len0_det_rst", det_rst, 0);
    chk("len0_busy", busy, 0); chk("len0_match", match_cnt, 0);
    tick();
    chk("len0_done_drop", done, 0);

    // clamp: len 20 applies 16 bits
    lb_run(16'hA5C3, 5'd20, 16, 8, 9, 1'b0);

    // start during RUN is ignored
    lb_run(16'h00B6, 5'd8, 8, 5, 6, 1'b1);

    // mid-run reset at the 3rd RUN cycle
    pattern = 16'h00B6; len = 5'd8; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    chk("pre_abort_match", match_cnt, 1);
    rst = 1'b0;
    tick();
    chk("abort_busy", busy, 0); chk("abort_done", done, 0); chk("abort_det_x", det_x, 0);
    chk("abort_det_rst", det_rst, 1); chk("abort_match", match_cnt, 0);
    rst = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("abort_no_done", done, 0);
    end
    lb_run(16'h00B6, 5'd8, 8, 5, 6, 1'b0);

    // saturation on the 2-bit-counter instance
    pattern2 = 16'hFFFF; len2 = 5'd16; start2 = 1'b1;
    tick();
    start2 = 1'b0;
    for (int i = 0; i < 17; i++) begin
      tick();
      chk("sat_no_early_done", done2, 0);
    end
    tick();
    chk("sat_done", done2, 1);
    chk("sat_match", match2, 3);
    chk("sat_xtgl", xtgl2, TGL ? 1 : 0);
    chk("sat_ztgl", ztgl2, TGL ? 1 : 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/seq_stim_ctrl.md
# seq_stim_ctrl

Stimulus sequencer and activity monitor for the `seq_detector` block in the power-estimation flow. Loads a bit pattern, clears the detector, shifts the pattern serially into its `x` input, samples `z` with fixed one-cycle detector latency, and reports the match count. Optionally reports toggle counts on `x` and `z`. Sits between the host/accelerator control path and one detector instance, replacing hand-written testbench stimulus in on-chip activity runs.

## Interface
- `PAT_W`, 16: pattern register width (max sequence length).
- `LEN_W`, 5: width of `len`; must satisfy 2^LEN_W > PAT_W.
- `CNT_W`, 8: width of all result counters.
- `clk`  in  1  single clock, all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-low.
- `start`  in  1  run request; honoured only in IDLE.
- `pattern`  in  PAT_W  stimulus bits; sampled with `start`.
- `len`  in  LEN_W  number of bits to apply; values > PAT_W clamp to PAT_W.
- `det_x`  out  1  serial stimulus to detector `x`.
- `det_rst`  out  1  active-high reset to detector.
- `det_z`  in  1  detector output `z`.
- `busy`  out  1  high in CLR, RUN, DRAIN.
- `done`  out  1  one-cycle completion pulse.
- `match_cnt`  out  CNT_W  sampled `det_z`==1 count.
- `x_tgl_cnt`  out  CNT_W  `det_x` transitions (see Configuration).
- `z_tgl_cnt`  out  CNT_W  sampled-`z` transitions (see Configuration).

## Operation
- States: IDLE, CLR, RUN, DRAIN, DONE. All outputs registered.
- IDLE: `busy`=0, `det_x`=0, `det_rst`=0. On `start`=1:
  - len==0: go to DONE; counters cleared, detector untouched.
  - else: latch `pattern` MSB-aligned (pattern << (PAT_W-len_c)), `remaining`=len_c (clamped), clear all counters, go to CLR.
- CLR: one cycle, `det_rst`=1, `det_x`=0; then RUN.
- RUN: `det_x` = shift-register MSB, so bits pattern[len_c-1] down to pattern[0] are applied in order, one per cycle. The register shifts left and `remaining` decrements each cycle. After `remaining`==1, go to DRAIN.
- DRAIN: one cycle, `det_x`=0; then DONE.
- DONE: `done`=1 for one cycle, `busy`=0; then IDLE. `start` is ignored here.
- `det_z` sampling points:
  - End of every RUN cycle except the first, plus the end of the DRAIN cycle.
  - Exactly len_c samples; sample k corresponds to bit k.
- `match_cnt` increments on each sampled 1. It saturates at 2^CNT_W-1.
- Counters hold their values from DONE until the next accepted `start`.
- `start` during CLR/RUN/DRAIN/DONE is ignored. `pattern`/`len` changes after acceptance have no effect.

## Timing
- Reset (`rst`=0 at an edge):
  - Next cycle: state IDLE, `busy`=0, `done`=0, `det_x`=0, `det_rst`=1.
  - All counters 0; shift register 0.
  - `det_rst` holds 1 while `rst`=0, and drops to 0 in the first IDLE cycle after release.
- Reset mid-run aborts immediately. No `done` is issued, and counters clear.
- Edge numbering: `start` accepted at edge E0.
  - CLR spans E0–E1.
  - RUN spans E1–E(len_c+1).
  - DRAIN spans E(len_c+1)–E(len_c+2).
  - DONE spans E(len_c+2)–E(len_c+3), with `done`=1.
- Samples are taken at E3..E(len_c+2).
- Latency from `start` to `done` is len_c+2 cycles; `busy` is high for len_c+2 cycles.
- len==0: DONE in the cycle after E0.
- Earliest restart: `start` accepted in the first IDLE cycle after DONE.

## Configuration
- `SEQ_CTRL_TOGGLE_EN` defined:
  - `x_tgl_cnt` counts RUN cycles where `det_x` differs from its previous RUN value; the previous value is 0 at RUN entry.
  - `z_tgl_cnt` counts samples differing from the previous sample; the previous sample is 0 at run start.
  - Both counters saturate and clear with `match_cnt`.
- Not defined: both ports tied to 0; no toggle registers are synthesised.

## Test plan
- Reset: hold `rst`=0 for 2 cycles -> `busy`=0, `done`=0, `det_x`=0, `det_rst`=1, all counts 0; after release, `det_rst`=0.
- Loopback run: bench model drives `det_z` = `det_x` registered once; `pattern`=16'h00B6, `len`=8, `start` pulse.
  - `det_x` = 1,0,1,1,0,1,1,0 in E1..E9.
  - `done` high in cycle E10–E11; `match_cnt`=5.
  - With macro: `x_tgl_cnt`=6 and `z_tgl_cnt`=6. Without macro: both 0.
- len==0 and clamp:
  - `len`=0 -> `done` next cycle, no `det_rst` pulse, counts 0.
  - `len`=20 -> exactly 16 bits applied.
- Busy protection: re-pulse `start` with a new `pattern` during RUN -> ignored; sequence and counts match the first pattern.
- Mid-run reset: `rst`=0 at 3rd RUN cycle -> IDLE next cycle, counts 0, `det_rst`=1, no `done`. A fresh run then completes normally.
- Saturation: `CNT_W`=2, `pattern`=16'hFFFF, `len`=16, loopback -> `match_cnt`=3; with macro, `x_tgl_cnt`=1 and `z_tgl_cnt`=1.
